// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the 64-bit ld/sd/add/sub datapath: IDLE -> DECODE -> EXEC -> WB.
// Optional macro CONTROLE_X0_GUARD_EN suppresses register writes whose destination is x0.
module unidade_controle #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [4:0]      Ra,
    output logic [4:0]      Rb,
    output logic [4:0]      Rw,
    output logic [XLEN-1:0] C,
    output logic            sinal,
    output logic            sinalMux,
    output logic            weReg,
    output logic            weMem,
    output logic            done,
    output logic            illegal
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    typedef enum logic [1:0] {WB_NONE, WB_REG, WB_MEM, WB_ILLEGAL} wb_kind_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [2:0] F3_D     = 3'b011;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [6:0] F7_SUB   = 7'b0100000;

    state_t     state;
    wb_kind_t   wb_kind;
    logic [31:0] instr_q;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    logic [4:0]      dec_ra, dec_rb, dec_rw;
    logic [XLEN-1:0] dec_c;
    logic            dec_sinal, dec_mux;
    wb_kind_t        dec_kind;
    wb_kind_t        reg_write_kind;

    // rd=x0 writes are either performed or silently dropped, depending on the build.
`ifdef CONTROLE_X0_GUARD_EN
    assign reg_write_kind = (rd == 5'd0) ? WB_NONE : WB_REG;
`else
    assign reg_write_kind = WB_REG;
`endif

    // Unsupported words fall through to the defaults: add-like outputs with rd forced to 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_ra    = rs1;
        dec_rb    = rs2;
        dec_rw    = 5'd0;
        dec_c     = '0;
        dec_sinal = 1'b0;
        dec_mux   = 1'b1;
        dec_kind  = WB_ILLEGAL;
        unique case (opcode)
            OP_LOAD: if (funct3 == F3_D) begin
                dec_rw   = rd;
                dec_c    = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
                dec_mux  = 1'b0;
                dec_kind = reg_write_kind;
            end
            OP_STORE: if (funct3 == F3_D) begin
                dec_c    = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
                dec_mux  = 1'b0;
                dec_kind = WB_MEM;
            end
            OP_REG: if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
                dec_rw    = rd;
                dec_sinal = (funct7 == F7_SUB);
                dec_kind  = reg_write_kind;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wb_kind     <= WB_NONE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            Ra          <= '0;
            Rb          <= '0;
            Rw          <= '0;
            C           <= '0;
            sinal       <= 1'b0;
            sinalMux    <= 1'b0;
            weReg       <= 1'b0;
            weMem       <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the pulse defaults below
            // are overridden later in the same block only in WB, giving single-cycle strobes.
            weReg   <= 1'b0;
            weMem   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    Ra       <= dec_ra;
                    Rb       <= dec_rb;
                    Rw       <= dec_rw;
                    C        <= dec_c;
                    sinal    <= dec_sinal;
                    sinalMux <= dec_mux;
                    wb_kind  <= dec_kind;
                    state    <= EXEC;
                end
                EXEC: state <= WB;
                WB: begin
                    weReg       <= (wb_kind == WB_REG);
                    weMem       <= (wb_kind == WB_MEM);
                    illegal     <= (wb_kind == WB_ILLEGAL);
                    done        <= 1'b1;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: table of single instructions plus back-to-back and reset sequences.
// Expected rd=x0 behaviour follows CONTROLE_X0_GUARD_EN when it is defined for the build.
module tb_unidade_controle;

    localparam int XLEN = 64;
`ifdef CONTROLE_X0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            instr_valid = 1'b0;
    logic [31:0]     instr = '0;
    logic            instr_ready;
    logic [4:0]      Ra, Rb, Rw;
    logic [XLEN-1:0] C;
    logic            sinal, sinalMux, weReg, weMem, done, illegal;

    unidade_controle #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .Ra(Ra), .Rb(Rb), .Rw(Rw), .C(C),
        .sinal(sinal), .sinalMux(sinalMux), .weReg(weReg), .weMem(weMem),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [4:0]  ra, rb, rw;
        bit          check_rw;
        logic [63:0] c;
        logic        sinal, mux, we_reg, we_mem, ill;
    } vec_t;

    task automatic check_pulses(input string tag, input logic r, input logic m, input logic d, input logic i);
        check({tag, " weReg"},   64'(weReg),   64'(r));
        check({tag, " weMem"},   64'(weMem),   64'(m));
        check({tag, " done"},    64'(done),    64'(d));
        check({tag, " illegal"}, 64'(illegal), 64'(i));
    endtask

    task automatic check_decode(input vec_t v, input string tag);
        check({v.name, tag, " Ra"}, 64'(Ra), 64'(v.ra));
        check({v.name, tag, " Rb"}, 64'(Rb), 64'(v.rb));
        if (v.check_rw) check({v.name, tag, " Rw"}, 64'(Rw), 64'(v.rw));
        check({v.name, tag, " C"}, C, v.c);
        check({v.name, tag, " sinal"}, 64'(sinal), 64'(v.sinal));
        check({v.name, tag, " sinalMux"}, 64'(sinalMux), 64'(v.mux));
    endtask

    // One full transaction: accept, DECODE, EXEC, WB, then the idle cycle after the strobe.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check({v.name, " ready before"}, 64'(instr_ready), 64'd1);
        instr = v.word;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 32'hDEAD_BEEF;
        check({v.name, " ready busy"}, 64'(instr_ready), 64'd0);
        @(posedge clk); #1;
        check_decode(v, "");
        check_pulses({v.name, " decode"}, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_pulses({v.name, " exec"}, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_pulses({v.name, " wb"}, v.we_reg, v.we_mem, 1'b1, v.ill);
        check({v.name, " ready wb"}, 64'(instr_ready), 64'd1);
        check_decode(v, " stable");
        @(posedge clk); #1;
        check_pulses({v.name, " after"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " ready"}, 64'(instr_ready), 64'd1);
        check({tag, " Ra"}, 64'(Ra), 64'd0);
        check({tag, " Rb"}, 64'(Rb), 64'd0);
        check({tag, " Rw"}, 64'(Rw), 64'd0);
        check({tag, " C"}, C, 64'd0);
        check({tag, " sinal"}, 64'(sinal), 64'd0);
        check({tag, " sinalMux"}, 64'(sinalMux), 64'd0);
        check_pulses(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        //          name            word          ra  rb  rw  chk c                        s  mux wr       wm ill
        vecs[0] = '{"ld x1,0",      32'h00003083, 0,  0,  1,  1, 64'h0,                   0, 0,  1,       0, 0};
        vecs[1] = '{"ld x2,-8",     32'hFF80B103, 1,  24, 2,  1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0,  1,       0, 0};
        vecs[2] = '{"ld max imm",   32'h7FF03083, 0,  31, 1,  1, 64'h7FF,                 0, 0,  1,       0, 0};
        vecs[3] = '{"ld min imm",   32'h80003083, 0,  0,  1,  1, 64'hFFFF_FFFF_FFFF_F800, 0, 0,  1,       0, 0};
        vecs[4] = '{"sd x6,8",      32'h0062B423, 5,  6,  0,  0, 64'h8,                   0, 0,  0,       1, 0};
        vecs[5] = '{"sub x4",       32'h40118233, 3,  1,  4,  1, 64'h0,                   1, 1,  1,       0, 0};
        vecs[6] = '{"illegal 0",    32'h00000000, 0,  0,  0,  1, 64'h0,                   0, 1,  0,       0, 1};
        vecs[7] = '{"lw unsupp",    32'h00002083, 0,  0,  0,  1, 64'h0,                   0, 1,  0,       0, 1};
        vecs[8] = '{"add x0",       32'h00108033, 1,  1,  0,  1, 64'h0,                   0, 1,  !GUARD,  0, 0};

        // Reset state held across clock edges
        repeat (2) @(posedge clk);
        #1 check_reset_values("reset");
        @(negedge clk) rst = 1'b0;
        #1 check_reset_values("post-reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back add then sub with instr_valid held high; sub appears during busy and must wait
        @(negedge clk);
        instr = 32'h001101B3;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr = 32'h40118233;
        check("b2b ready after accept1", 64'(instr_ready), 64'd0);
        @(posedge clk); #1;
        check("b2b add Rw", 64'(Rw), 64'd3);
        check("b2b add Ra", 64'(Ra), 64'd2);
        check("b2b add sinal", 64'(sinal), 64'd0);
        check("b2b add sinalMux", 64'(sinalMux), 64'd1);
        @(posedge clk); #1;
        check("b2b ready exec", 64'(instr_ready), 64'd0);
        @(posedge clk); #1;
        check_pulses("b2b add wb", 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("b2b ready after accept2", 64'(instr_ready), 64'd0);
        check("b2b weReg cleared", 64'(weReg), 64'd0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b sub Rw", 64'(Rw), 64'd4);
        check("b2b sub Ra", 64'(Ra), 64'd3);
        check("b2b sub sinal", 64'(sinal), 64'd1);
        check("b2b sub sinalMux", 64'(sinalMux), 64'd1);
        repeat (2) @(posedge clk);
        #1 check_pulses("b2b sub wb", 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_pulses("b2b sub after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during EXEC of an add drops the write
        @(negedge clk);
        instr = 32'h001101B3;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("rst-exec Rw decoded", 64'(Rw), 64'd3);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_values("rst async");
        repeat (3) begin
            @(posedge clk); #1;
            check("rst held weReg", 64'(weReg), 64'd0);
        end
        @(negedge clk) rst = 1'b0;
        #1 check_reset_values("rst released");
        repeat (4) begin
            @(posedge clk); #1;
            check("rst idle weReg", 64'(weReg), 64'd0);
            check("rst idle done", 64'(done), 64'd0);
        end
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
